// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment value path: digit codes, FSM encoding, BCD sizing.
package seg7_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hA;
  localparam logic [3:0] DIG_OVF   = 4'hB;
  localparam logic [3:0] DIG_MINUS = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_FMT  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // One spare BCD digit above the displayed ones, used only to detect overflow.
  function automatic int unsigned bcdWidth(input int unsigned numDig);
    return 4 * (numDig + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one magnitude bit per clock.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned NUM_DIG = 4
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             start,
  input  logic [DATA_W-1:0]                magIn,
  output logic                             done,
  output logic [bcdWidth(NUM_DIG)-1:0]     bcd
);

  localparam int unsigned BCD_W  = bcdWidth(NUM_DIG);
  localparam int unsigned ITER_W = $clog2(DATA_W + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W - 1);

  logic [DATA_W-1:0] magQ;
  logic [BCD_W-1:0]  bcdQ;
  logic [BCD_W-1:0]  bcdAdj;
  logic [ITER_W-1:0] iterQ;
  logic              runQ;

  always_comb begin
    bcdAdj = bcdQ;
    for (int k = 0; k <= int'(NUM_DIG); k++) begin
      if (bcdQ[4*k +: 4] >= 4'd5) bcdAdj[4*k +: 4] = bcdQ[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      runQ  <= 1'b0;
      iterQ <= '0;
      magQ  <= '0;
      bcdQ  <= '0;
    end else if (start) begin
      runQ  <= 1'b1;
      iterQ <= '0;
      magQ  <= magIn;
      bcdQ  <= '0;
    end else if (runQ) begin
      bcdQ  <= {bcdAdj[BCD_W-2:0], magQ[DATA_W-1]};
      magQ  <= magQ << 1;
      iterQ <= iterQ + ITER_W'(1);
      if (iterQ == ITER_LAST) runQ <= 1'b0;
    end
  end

  // done marks the final shift cycle; bcd holds the full result from the next cycle on.
  assign done = runQ && (iterQ == ITER_LAST);
  assign bcd  = bcdQ;

endmodule

// File: rtl/seg7_value_ctrl.sv
// Accepts signed readings, converts them to display digit codes and holds each result on screen.
module seg7_value_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned NUM_DIG  = 4,
  parameter int unsigned HOLD_CYC = 5000000
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [DATA_W-1:0]      iDATA,
  input  logic                   iVALID,
  output logic                   oREADY,
  input  logic                   iBLANK,
  output logic [4*NUM_DIG-1:0]   oDIG,
  output logic                   oUPD,
  output logic                   oBUSY
);

  localparam int unsigned BCD_W = bcdWidth(NUM_DIG);
  localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [4*NUM_DIG-1:0] DIG_RESET = {{(NUM_DIG-1){DIG_BLANK}}, 4'h0};

  logic [1:0]           stateQ, stateD;
  logic                 signQ;
  logic [4*NUM_DIG-1:0] digQ, digD;
  logic                 updQ;
  logic [CNT_W-1:0]     cntQ;
  logic                 ready, start, convDone, ovf;
  logic [DATA_W-1:0]    mag;
  logic [BCD_W-1:0]     bcd;
  int                   msd;

  assign ready = iRST_N && (stateQ == ST_IDLE);
  assign start = ready && iVALID;
  // Unsigned magnitude keeps the most-negative input as 2^(DATA_W-1).
  assign mag   = iDATA[DATA_W-1] ? (~iDATA + DATA_W'(1)) : iDATA;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .NUM_DIG(NUM_DIG)
  ) uConv (
    .clk  (iCLK),
    .rstN (iRST_N),
    .start(start),
    .magIn(mag),
    .done (convDone),
    .bcd  (bcd)
  );

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      ST_IDLE: if (iVALID) stateD = ST_CONV;
      ST_CONV: if (convDone) stateD = ST_FMT;
      ST_FMT:  stateD = (HOLD_CYC == 0) ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (cntQ == CNT_LAST) stateD = ST_IDLE;
      default: stateD = ST_IDLE;
    endcase
  end

  always_comb begin
    msd  = 0;
    digD = '0;
    for (int k = 1; k < int'(NUM_DIG); k++) begin
      if (bcd[4*k +: 4] != 4'd0) msd = k;
    end
    ovf = (bcd[4*NUM_DIG +: 4] != 4'd0) || (signQ && (bcd[4*(NUM_DIG-1) +: 4] != 4'd0));
    for (int k = 0; k < int'(NUM_DIG); k++) begin
      if (ovf)                          digD[4*k +: 4] = DIG_OVF;
      else if (k <= msd)                digD[4*k +: 4] = bcd[4*k +: 4];
      else if (signQ && k == msd + 1)   digD[4*k +: 4] = DIG_MINUS;
      else                              digD[4*k +: 4] = DIG_BLANK;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      stateQ <= ST_IDLE;
      signQ  <= 1'b0;
      digQ   <= DIG_RESET;
      updQ   <= 1'b0;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      updQ   <= (stateQ == ST_FMT);
      if (start) signQ <= iDATA[DATA_W-1];
      if (stateQ == ST_FMT) digQ <= digD;
      if (stateQ == ST_HOLD) cntQ <= (cntQ == CNT_LAST) ? '0 : cntQ + CNT_W'(1);
    end
  end

  assign oREADY = ready;
  assign oBUSY  = (stateQ != ST_IDLE);
  assign oUPD   = updQ;
  assign oDIG   = iBLANK ? {NUM_DIG{DIG_BLANK}} : digQ;

endmodule
